// File: rtl/svpwm_pkg.sv
// svpwm_pkg: shared state encoding, widths, period limit and leg bit map
// for the svpwm sequencer (svpwm_ctrl, svpwm_deadtime, svpwm_ctrl_if).
package svpwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int CNT_W      = 16;
  localparam int VIN_W      = 16;
  localparam int DT_W       = 8;
  localparam int FILL_W     = 8;
  localparam int PERIOD_MAX = 32767;

  // leg k drives high side LEG_HI[k] and low side LEG_LO[k]
  localparam logic [2:0][2:0] LEG_HI = {3'd4, 3'd2, 3'd0};
  localparam logic [2:0][2:0] LEG_LO = {3'd1, 3'd5, 3'd3};

endpackage

// File: rtl/svpwm_ctrl_if.sv
// svpwm_ctrl_if: regulator -> sequencer sample handshake.
// master (regulator): drives vin_alpha/vin_beta/vin_valid, sees vin_ready.
interface svpwm_ctrl_if;
  import svpwm_pkg::*;

  logic signed [VIN_W-1:0] vin_alpha;
  logic signed [VIN_W-1:0] vin_beta;
  logic                    vin_valid;
  logic                    vin_ready;

  modport master (
    output vin_alpha,
    output vin_beta,
    output vin_valid,
    input  vin_ready
  );

  modport slave (
    input  vin_alpha,
    input  vin_beta,
    input  vin_valid,
    output vin_ready
  );

endinterface

// File: rtl/svpwm_deadtime.sv
// svpwm_deadtime: one inverter leg with dead-time insertion.
// Ports: clk, rst_n, raw_hi (raw high-side), run (state==RUN); hi, lo out.
module svpwm_deadtime
  import svpwm_pkg::*;
#(
  parameter int DEAD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_hi,
  input  logic run,
  output logic hi,
  output logic lo
);

  logic            prev;
  logic [DT_W-1:0] dcnt;

  // dcnt==1 is the last blanked cycle, so the pair is off exactly DEAD cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      dcnt <= DT_W'(DEAD);
      hi   <= 1'b0;
      lo   <= 1'b0;
    end else begin
      prev <= raw_hi;
      if (!run || (raw_hi != prev)) begin
        dcnt <= DT_W'(DEAD);
        hi   <= 1'b0;
        lo   <= 1'b0;
      end else if (dcnt > DT_W'(1)) begin
        dcnt <= dcnt - 1'b1;
      end else begin
        dcnt <= '0;
        hi   <= raw_hi;
        lo   <= ~raw_hi;
      end
    end
  end

endmodule

// File: rtl/svpwm_ctrl.sv
// svpwm_ctrl: carrier, sample latch, fill/run/fault FSM, dead-time gates.
// Ports: clk, rst_n, enable, period_in, fault, fault_clr, vin (slave),
// V_alpha, V_beta, carrier, gate_raw, gate_out, state, underrun, cfg_err.
// Macro SVPWM_DOUBLE_UPDATE_EN: the carrier peak is also an update point.
module svpwm_ctrl #(
  parameter int PIPE_LAT = 5,
  parameter int DEAD     = 8,
  parameter int CNT_W    = svpwm_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period_in,
  input  logic              fault,
  input  logic              fault_clr,
  svpwm_ctrl_if.slave       vin,
  output logic signed [15:0] V_alpha,
  output logic signed [15:0] V_beta,
  output logic signed [CNT_W-1:0] carrier,
  input  logic [5:0]        gate_raw,
  output logic [5:0]        gate_out,
  output logic [1:0]        state,
  output logic              underrun,
  output logic              cfg_err
);
  import svpwm_pkg::*;

  localparam int PW = CNT_W - 1;

  state_t            st;
  logic [PW-1:0]     cnt;
  logic [PW-1:0]     per_q;
  logic              dn;
  logic              stop_pend;
  logic [FILL_W-1:0] fill_cnt;
  logic              per_ok;
  logic              valley;
  logic              peak;
  logic              upd;
  logic              run;
  logic [5:0]        dt;
  logic              unused_raw;

  assign per_ok = (period_in != '0) &&
                  (period_in <= CNT_W'(PERIOD_MAX));
  assign valley = (cnt == '0);
`ifdef SVPWM_DOUBLE_UPDATE_EN
  assign peak = !dn && (cnt == per_q);
`else
  assign peak = 1'b0;
`endif
  assign upd = ((st == ST_FILL) || (st == ST_RUN)) &&
               !fault && (valley || peak);

  assign vin.vin_ready = upd;
  assign carrier = {1'b0, cnt};
  assign state   = st;
  assign run     = (st == ST_RUN);

  // fault masks the gates in the same cycle, before the state register
  assign gate_out = (run && !fault) ? dt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      per_q     <= '0;
      dn        <= 1'b0;
      stop_pend <= 1'b0;
      fill_cnt  <= '0;
      V_alpha   <= '0;
      V_beta    <= '0;
      underrun  <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (fault) begin
      st        <= ST_FAULT;
      stop_pend <= 1'b0;
      fill_cnt  <= '0;
    end else begin
      if (upd) begin
        if (vin.vin_valid) begin
          V_alpha <= vin.vin_alpha;
          V_beta  <= vin.vin_beta;
        end else begin
          underrun <= 1'b1;
        end
      end
      unique case (st)
        ST_IDLE: begin
          cnt       <= '0;
          dn        <= 1'b0;
          stop_pend <= 1'b0;
          fill_cnt  <= '0;
          if (enable && per_ok) begin
            per_q <= period_in[PW-1:0];
            st    <= ST_FILL;
          end else if (enable) begin
            cfg_err <= 1'b1;
          end
        end
        ST_FILL, ST_RUN: begin
          // period only moves at a valley, so a half-cycle never shrinks
          if (valley) begin
            cnt <= PW'(1);
            dn  <= 1'b0;
            if (per_ok) begin
              per_q <= period_in[PW-1:0];
            end else if (enable) begin
              cfg_err <= 1'b1;
            end
          end else if (dn) begin
            cnt <= cnt - PW'(1);
          end else if (cnt >= per_q) begin
            cnt <= cnt - PW'(1);
            dn  <= 1'b1;
          end else begin
            cnt <= cnt + PW'(1);
          end
          if (st == ST_FILL) begin
            if (!enable) begin
              st       <= ST_IDLE;
              cnt      <= '0;
              dn       <= 1'b0;
              fill_cnt <= '0;
            end else if (fill_cnt == FILL_W'(1)) begin
              st       <= ST_RUN;
              fill_cnt <= '0;
            end else if (fill_cnt != '0) begin
              fill_cnt <= fill_cnt - 1'b1;
            end else if (upd && vin.vin_valid) begin
              fill_cnt <= FILL_W'(PIPE_LAT);
            end
          end else if (!enable || stop_pend) begin
            if (valley) begin
              st        <= ST_IDLE;
              cnt       <= '0;
              dn        <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              stop_pend <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            st  <= ST_IDLE;
            cnt <= '0;
            dn  <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_leg
    svpwm_deadtime #(
      .DEAD(DEAD)
    ) u_leg (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_hi (gate_raw[LEG_HI[i]]),
      .run    (run),
      .hi     (dt[LEG_HI[i]]),
      .lo     (dt[LEG_LO[i]])
    );
  end

  // low-side raw bits are implied by the high side
  assign unused_raw = ^{gate_raw[LEG_LO[0]],
                        gate_raw[LEG_LO[1]],
                        gate_raw[LEG_LO[2]]};

endmodule
